// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enable scratch RAM with hardware clear.
package ram_pkg;

  // Width of one byte lane gated by a single byte-enable bit.
  localparam int BYTE_W = 8;

  // Widest word the merge helper handles; callers zero-extend into it.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / BYTE_W;

  // Sequencer state: sweeping zeros through the array, or serving commands.
  typedef enum logic {
    RAM_CLEAR = 1'b0,
    RAM_READY = 1'b1
  } ram_state_t;

  // Returns old_word with every byte lane whose enable is set replaced by
  // the matching lane of new_word. Lanes with be=0 keep their old value.
  function automatic logic [MAX_DATA_W-1:0] be_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) begin
        merged[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: owns the CLEAR/READY state and the sweep address counter.
// While clearing it asks the array to write zero at one address per cycle.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clrReq,
  output logic              o_ready,
  output logic              o_clrWe,
  output logic [ADDR_W-1:0] o_clrAddr
);

  ram_state_t        r_state;
  logic [ADDR_W-1:0] r_clrCnt;

  // State and sweep counter; the counter wraps to 0 when leaving CLEAR so a
  // later clear request always starts from address 0.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= RAM_CLEAR;
      r_clrCnt <= '0;
    end else begin
      case (r_state)
        RAM_CLEAR: begin
          r_clrCnt <= r_clrCnt + 1'b1;
          if (&r_clrCnt) begin
            r_state <= RAM_READY;
          end
        end
        RAM_READY: begin
          if (i_clrReq) begin
            r_state  <= RAM_CLEAR;
            r_clrCnt <= '0;
          end
        end
        default: begin
          r_state  <= RAM_CLEAR;
          r_clrCnt <= '0;
        end
      endcase
    end
  end

  assign o_ready   = (r_state == RAM_READY);
  assign o_clrWe   = (r_state == RAM_CLEAR);
  assign o_clrAddr = r_clrCnt;

endmodule

// File: rtl/ram_be_clr.sv
// Single-port scratch RAM with per-byte write enables, a registered read
// port with a valid strobe, and a hardware clear sweep after reset or on
// request. Commands are only honoured while ready is high.
module ram_be_clr
  import ram_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 4,
  localparam int DEPTH  = 2**ADDR_W,
  localparam int BE_W   = DATA_W / BYTE_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              clr_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              ready,
  output logic              cmd_err
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdData;
  logic              r_rdValid;
  logic              r_cmdErr;

  logic              w_ready;
  logic              w_clrWe;
  logic [ADDR_W-1:0] w_clrAddr;
  logic              w_anyCmd;
  logic              w_conflict;
  logic              w_wrAccept;
  logic              w_rdAccept;
  logic              w_reject;
  logic [DATA_W-1:0] w_mergeData;

  ram_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clrSeq (
    .i_clk     (Clk),
    .i_rst_n   (Rst_n),
    .i_clrReq  (clr_req),
    .o_ready   (w_ready),
    .o_clrWe   (w_clrWe),
    .o_clrAddr (w_clrAddr)
  );

  // A command is taken only in READY with no clear request and no
  // read/write conflict; everything else presented is rejected.
  assign w_anyCmd   = wr_en | rd_en;
  assign w_conflict = wr_en & rd_en;
  assign w_wrAccept = w_ready & ~clr_req & wr_en & ~rd_en;
  assign w_rdAccept = w_ready & ~clr_req & rd_en & ~wr_en;
  assign w_reject   = w_anyCmd & (~w_ready | clr_req | w_conflict);

  assign w_mergeData = DATA_W'(be_merge(MAX_DATA_W'(r_mem[Addr]),
                                        MAX_DATA_W'(wr_data),
                                        MAX_BE_W'(wr_be)));

  // Array write port: the clear sweep and user writes never overlap because
  // user writes require READY. Nothing is written while reset is held.
  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      if (w_clrWe) begin
        r_mem[w_clrAddr] <= '0;
      end else if (w_wrAccept) begin
        r_mem[Addr] <= w_mergeData;
      end
    end
  end

  // Read register and status strobes; rd_data only changes on an accepted
  // read so it survives a clear sweep untouched.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_rdData  <= '0;
      r_rdValid <= 1'b0;
      r_cmdErr  <= 1'b0;
    end else begin
      r_rdValid <= w_rdAccept;
      r_cmdErr  <= w_reject;
      if (w_rdAccept) begin
        r_rdData <= r_mem[Addr];
      end
    end
  end

  assign rd_data  = r_rdData;
  assign rd_valid = r_rdValid;
  assign cmd_err  = r_cmdErr;
  assign ready    = w_ready;

endmodule

// File: tb/tb_ram_be_clr.sv
// Bench for ram_be_clr built with 32-bit words and 16 entries. A reference
// model tracks memory, clear progress and the expected strobes; outputs are
// compared against it on every falling edge, and directed steps pin key
// values with literals.
module tb_ram_be_clr;

  logic        Clk;
  logic        Rst_n;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  Addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        clr_req;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        ready;
  logic        cmd_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdlMem [16];
  logic [31:0] mdlRdData;
  logic        mdlRdValid;
  logic        mdlCmdErr;
  logic        mdlReady;
  int          mdlClrLeft;
  logic        mdlInit = 1'b0;

  ram_be_clr #(
    .DATA_W (32),
    .ADDR_W (4)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .Addr     (Addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .clr_req  (clr_req),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .ready    (ready),
    .cmd_err  (cmd_err)
  );

  // Free-running clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: a clear takes 16 cycles counted down, then commands are
  // honoured one per cycle; anything refused produces an error pulse.
  always @(posedge Clk) begin
    if (!Rst_n) begin
      mdlInit    <= 1'b1;
      mdlReady   <= 1'b0;
      mdlClrLeft <= 16;
      mdlRdData  <= '0;
      mdlRdValid <= 1'b0;
      mdlCmdErr  <= 1'b0;
    end else if (!mdlReady) begin
      mdlMem[16 - mdlClrLeft] <= '0;
      mdlClrLeft <= mdlClrLeft - 1;
      mdlReady   <= (mdlClrLeft == 1);
      mdlRdValid <= 1'b0;
      mdlCmdErr  <= wr_en | rd_en;
    end else begin
      mdlRdValid <= 1'b0;
      mdlCmdErr  <= 1'b0;
      if (clr_req) begin
        mdlReady   <= 1'b0;
        mdlClrLeft <= 16;
        mdlCmdErr  <= wr_en | rd_en;
      end else if (wr_en && rd_en) begin
        mdlCmdErr <= 1'b1;
      end else if (wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_be[b]) mdlMem[Addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end else if (rd_en) begin
        mdlRdData  <= mdlMem[Addr];
        mdlRdValid <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (mdlInit) begin
      checkOutput("cycReady", {31'd0, ready}, {31'd0, mdlReady});
      checkOutput("cycRdValid", {31'd0, rd_valid}, {31'd0, mdlRdValid});
      checkOutput("cycCmdErr", {31'd0, cmd_err}, {31'd0, mdlCmdErr});
      checkOutput("cycRdData", rd_data, mdlRdData);
    end
  end

  // Presents one command for a single rising edge, then returns to idle
  // just after that edge so results of the command are visible.
  task automatic applyStimulus(input logic w, input logic r, input logic c,
                               input logic [3:0] a, input logic [31:0] d,
                               input logic [3:0] be);
    wr_en   = w;
    rd_en   = r;
    clr_req = c;
    Addr    = a;
    wr_data = d;
    wr_be   = be;
    @(posedge Clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Counts edges until ready rises, with a bound, and checks the count.
  task automatic waitReady(input string name, input int expCycles,
                           input int alreadyDone);
    int n;
    n = alreadyDone;
    while (ready !== 1'b1 && n < 64) begin
      @(posedge Clk);
      #1;
      n++;
    end
    checkOutput(name, 32'(n), 32'(expCycles));
  endtask

  task automatic readAllZero(input string name);
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'(a), 32'h0, 4'h0);
      checkOutput(name, rd_data, 32'h0000_0000);
    end
  endtask

  initial begin
    Rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_req = 1'b0;
    Addr    = '0;
    wr_data = '0;
    wr_be   = '0;

    idleCycles(2);
    checkOutput("rstReady", {31'd0, ready}, 32'd0);
    checkOutput("rstRdValid", {31'd0, rd_valid}, 32'd0);
    checkOutput("rstCmdErr", {31'd0, cmd_err}, 32'd0);
    checkOutput("rstRdData", rd_data, 32'h0);

    Rst_n = 1'b1;
    waitReady("rstToReady", 16, 0);
    readAllZero("initZero");
    checkOutput("initRdValid", {31'd0, rd_valid}, 32'd1);

    applyStimulus(1'b1, 1'b0, 1'b0, 4'd3, 32'h0000_00A5, 4'b0001);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    checkOutput("wrRdA5", rd_data, 32'h0000_00A5);
    checkOutput("wrRdValid", {31'd0, rd_valid}, 32'd1);
    idleCycles(1);
    checkOutput("holdA5", rd_data, 32'h0000_00A5);
    checkOutput("holdValid", {31'd0, rd_valid}, 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 4'd5, 32'h1122_3344, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd5, 32'hAABB_CCDD, 4'b0101);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    checkOutput("beMerge", rd_data, 32'h11BB_33DD);

    applyStimulus(1'b1, 1'b0, 1'b0, 4'd5, 32'hFFFF_FFFF, 4'h0);
    checkOutput("beZeroErr", {31'd0, cmd_err}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    checkOutput("beZeroKeep", rd_data, 32'h11BB_33DD);

    applyStimulus(1'b1, 1'b0, 1'b0, 4'd2, 32'h0000_005A, 4'hF);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd2, 32'hFFFF_FFFF, 4'hF);
    checkOutput("conflictErr", {31'd0, cmd_err}, 32'd1);
    checkOutput("conflictNoRd", {31'd0, rd_valid}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd2, 32'h0, 4'h0);
    checkOutput("conflictKeep", rd_data, 32'h0000_005A);

    applyStimulus(1'b1, 1'b0, 1'b0, 4'd7, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd7, 32'h0, 4'h0);
    checkOutput("wrThenRd", rd_data, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 1'b0, 1'b1, 4'd9, 32'h1234_5678, 4'hF);
    checkOutput("clrErr", {31'd0, cmd_err}, 32'd1);
    checkOutput("clrReadyLow", {31'd0, ready}, 32'd0);
    waitReady("clrToReady", 16, 0);
    checkOutput("clrKeepRd", rd_data, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd9, 32'h0, 4'h0);
    checkOutput("clrNoWrite", rd_data, 32'h0);
    readAllZero("clrZero");

    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 32'hCAFE_F00D, 4'hF);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 32'h0, 4'h0);
    idleCycles(7);
    Rst_n = 1'b0;
    idleCycles(1);
    Rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd4, 32'h0, 4'h0);
    checkOutput("clearRdErr", {31'd0, cmd_err}, 32'd1);
    checkOutput("clearRdNoValid", {31'd0, rd_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 32'hFFFF_FFFF, 4'hF);
    checkOutput("clearWrErr", {31'd0, cmd_err}, 32'd1);
    waitReady("midRstToReady", 16, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 32'h0, 4'h0);
    checkOutput("clearWrDropped", rd_data, 32'h0);
    readAllZero("rstZero");
    idleCycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_be_clr.md
Name: ram_be_clr

Overview:
Parametrised synchronous single-port RAM. It succeeds the fixed 16x8 tristate-bus RAM.
- Separate write and read data buses replace the bidirectional bus.
- Adds per-byte write enables, a registered read with a valid strobe, and a hardware clear sequencer that zeroes the array after reset or on request.
- Sits as local scratch storage beside datapath blocks; the controller must wait for ready before issuing commands.

Parameters:
- DATA_W, 8, data word width in bits; must be a multiple of 8.
- ADDR_W, 4, address width.
- DEPTH, 2**ADDR_W, number of words; derived, not overridden.
- BE_W, DATA_W/8, number of byte enables; derived.

Ports:
- Clk  input  1  sole clock; all logic on the rising edge.
- Rst_n  input  1  reset, synchronous, active-low.
- wr_en  input  1  write command.
- rd_en  input  1  read command.
- Addr  input  ADDR_W  word address.
- wr_data  input  DATA_W  write data.
- wr_be  input  BE_W  byte enables; bit i gates wr_data[8i+7:8i].
- clr_req  input  1  request a full-array clear.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  1  one-cycle strobe; rd_data is new this cycle.
- ready  output  1  block accepts commands.
- cmd_err  output  1  one-cycle strobe; a command was rejected.

Behaviour:
- Reset (Rst_n=0 at a rising edge):
  - state=CLEAR, clear counter=0.
  - rd_data=0, rd_valid=0, ready=0, cmd_err=0.
  - Memory contents are not reset directly; the CLEAR sweep zeroes them.
  - Reset mid-CLEAR restarts the sweep at address 0.
  - Reset in READY abandons any command presented in that cycle.
- CLEAR state:
  - Writes 0 to one address per cycle, counter 0..DEPTH-1.
  - After writing DEPTH-1, next state is READY. ready rises exactly DEPTH cycles after reset deassertion (16 cycles at defaults).
  - Any wr_en or rd_en seen in CLEAR is dropped and cmd_err pulses the next cycle.
  - clr_req is ignored in CLEAR.
- READY state, ready=1; inputs are sampled at each rising edge:
  - clr_req=1: next state CLEAR, counter=0, ready drops next cycle. clr_req has priority: a same-cycle wr_en/rd_en is dropped and cmd_err pulses.
  - wr_en=1, rd_en=0: for each i with wr_be[i]=1, write byte i of MEMORY[Addr] from wr_data. Bytes with wr_be[i]=0 keep their value. wr_be=0 is a legal no-op and raises no error.
  - rd_en=1, wr_en=0: rd_data <= MEMORY[Addr] and rd_valid=1, both visible the cycle after the command (latency 1).
  - wr_en=1 and rd_en=1: conflict. No memory change, no read, cmd_err=1 next cycle.
  - Neither command: nothing happens.
- rd_data holds its last value until the next accepted read or reset. It is not cleared by a CLEAR sweep.
- rd_valid and cmd_err are single-cycle pulses, never both high in the same cycle.
- Back-to-back commands are accepted every cycle in READY.
- A write to address A followed by a read of A in the next cycle returns the newly written data.
- Addr covers the whole array, so there is no out-of-range case.
- State encoding is 2 states; a binary encoding is adequate.

Decomposition:
- Shared package ram_pkg holds:
  - state enum ram_state_t {RAM_CLEAR, RAM_READY}.
  - localparam BYTE_W=8.
  - function be_merge(old, new, be) returning the byte-masked word.
- One natural sub-module, ram_clr_seq: holds the CLEAR/READY state register and the clear counter, and outputs ready, clr_we and clr_addr. The top level muxes the clear write against user writes and holds the array, read register and error logic.

Test Plan:
- Reset release -> ready=0 for cycles 1..16, ready=1 from cycle 17. A read of every address returns 0x00 with rd_valid one cycle after each rd_en.
- Write Addr=3, wr_data=0xA5, wr_be=1; next cycle read Addr=3 -> rd_data=0xA5, rd_valid=1 for exactly one cycle. Idle cycles afterwards hold rd_data=0xA5, rd_valid=0.
- DATA_W=32 build: write Addr=5 0x11223344 with be=4'hF, then 0xAABBCCDD with be=4'b0101 -> read returns 0x11BB33DD.
- wr_en=1 and rd_en=1 together at Addr=2 (contents 0x5A) -> cmd_err=1 one cycle, rd_valid=0, later read of Addr=2 returns 0x5A.
- clr_req=1 with wr_en=1 same cycle -> cmd_err pulses, ready=0 for 16 cycles, write not performed. After ready returns, every address reads 0x00. rd_data keeps its pre-clear value until the first new read.
- Assert Rst_n=0 at cycle 8 of a CLEAR sweep, release -> ready returns exactly 16 cycles after release. A read issued during CLEAR gives cmd_err=1 and rd_valid=0.
